modulo_mostrar_resultado: RTL and testbench
===========================================

# modulo_mostrar_resultado

Output-side counterpart of the digit-entry FSM. It accepts a finished multi-digit BCD result through a valid/ready handshake. It then presents the digits one at a time, most significant first, using the same per-digit `enable` pulse / end-of-number pulse protocol that the entry path uses. It feeds the display driver, holds each digit for a fixed number of cycles, blanks leading zeros, and flags non-BCD digits.

## Interface
- `DIGITS`, 4: number of BCD digits per result (≥2).
- `HOLD_CYCLES`, 4: cycles each digit slot lasts, including its enable cycle (≥2).
- `BLANK_ZEROS`, 1: 1 = suppress leading zeros; 0 = show all digits.
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `resultado_valid`  in  1  result available.
- `resultado`  in  4*DIGITS  BCD result, digit i at bits [4i+3:4i], digit 0 is units.
- `resultado_ready`  out  1  block idle and can accept a result.
- `digito`  out  4  current digit value; 4'hF when blanked, 4'hE when non-BCD.
- `digito_pos`  out  $clog2(DIGITS)  position of the current digit.
- `digito_en`  out  1  one-cycle pulse in the first cycle of each digit slot.
- `mostrar`  out  1  high during a slot whose digit is shown; low when blanked or idle.
- `fin`  out  1  one-cycle pulse after the last slot.
- `error`  out  1  high from accept until the next accept if any captured digit > 9.

## Operation
- FSM states: ESPERAR, ENABLE, MOSTRAR, FIN. Outputs are decoded from the registered state and datapath (Moore).
- Reset (`reset`==0 at a clock edge) has priority over every other input.
  - State goes to ESPERAR; the captured result is discarded.
  - Outputs after reset: `resultado_ready`=1; `digito`=0, `digito_pos`=0, `digito_en`=0, `mostrar`=0, `fin`=0, `error`=0.
- ESPERAR: `resultado_ready`=1.
  - If `resultado_valid` & `resultado_ready` at an edge: latch `resultado`, set position to DIGITS-1, compute `error`, go to ENABLE.
- ENABLE: `digito_en`=1, hold counter cleared, go to MOSTRAR.
- MOSTRAR: the counter increments each cycle.
  - When the slot reaches HOLD_CYCLES cycles (ENABLE cycle included):
    - if position==0, go to FIN;
    - otherwise decrement the position and go to ENABLE.
- FIN: `fin`=1 for one cycle, then go to ESPERAR.
- Blanking: a slot is blanked when BLANK_ZEROS=1, the digit is 0, all more-significant digits are 0, and position≠0.
  - The units digit is never blanked.
  - A blanked slot still consumes HOLD_CYCLES cycles and still pulses `digito_en`.
- A non-BCD digit (>9) outputs 4'hE with `mostrar`=1. It counts as nonzero for the blanking rule.
- `resultado_valid` while busy is ignored (`resultado_ready`=0). No input is buffered.

## Timing
- Accept edge = cycle 0.
- ENABLE of slot k (k=0 is the MS digit) occurs at cycle 1+k·HOLD_CYCLES.
- FIN occurs at cycle 1+DIGITS·HOLD_CYCLES; `resultado_ready` returns the cycle after.
- Total busy time: DIGITS·HOLD_CYCLES+1 cycles.
- With defaults: `digito_en` at cycles 1, 5, 9, 13; `fin` at 17; next accept possible at the cycle-18 edge.
- `digito`, `digito_pos` and `mostrar` are stable for the whole slot, ENABLE cycle included.
- Reset low mid-transfer: the next cycle shows ESPERAR outputs; no `fin` pulse is emitted.

## Structure
- Shared package (`calc_pkg`) holds:
  - state encoding constants ESPERAR/ENABLE/MOSTRAR/FIN (2 bits);
  - display codes BLANK=4'hF and ERR=4'hE;
  - BCD digit width 4.
  - The digit-entry FSM uses the same package.
- Sub-module `contador_permanencia`:
  - parameterised by HOLD_CYCLES;
  - inputs: clear and enable;
  - output: terminal-count flag.
- Leading-zero detection is a small combinational function kept inside this module.

## Test plan
- Defaults, `resultado`=16'h0042 → slots pos3/pos2 blanked (`digito`=F, `mostrar`=0), pos1=4, pos0=2; `digito_en` at cycles 1/5/9/13, `fin` at 17, `error`=0.
- `resultado`=16'h0000 → only pos0 shown as 0; the three upper slots blanked; `fin` at 17.
- `resultado`=16'h1A05 → `error`=1 from cycle 1; pos3=1, pos2=E, pos1=0 shown (not blanked), pos0=5.
- `resultado_valid` held high continuously with 16'h1234 → digits 1, 2, 3, 4 in order; second accept at the cycle-18 edge; inputs applied during busy ignored.
- `reset`=0 at cycle 7 mid-transfer → cycle 8 shows `resultado_ready`=1 with all other outputs 0; no `fin`; a new accept works normally.
- BLANK_ZEROS=0, HOLD_CYCLES=2, 16'h0007 → all four digits shown (0, 0, 0, 7); `digito_en` at 1/3/5/7, `fin` at 9.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator digit paths: FSM state encoding,
// display codes and BCD digit width. The digit-entry FSM imports it too.
package calc_pkg;

   localparam int unsigned BCD_W = 4;

   // Display codes driven on the digit bus instead of a real digit
   localparam logic [BCD_W-1:0] BLANK = 4'hF;
   localparam logic [BCD_W-1:0] ERR   = 4'hE;

   typedef enum logic [1:0] {
      ESPERAR = 2'd0,
      ENABLE  = 2'd1,
      MOSTRAR = 2'd2,
      FIN     = 2'd3
   } estado_t;

endpackage

// File: rtl/modulo_mostrar_resultado_if.sv
// Result handshake plus per-digit display bus of the result output path.
// master: result producer / display consumer; slave: modulo_mostrar_resultado.
interface modulo_mostrar_resultado_if #(
   parameter int unsigned DIGITS = 4
) ();

   localparam int unsigned POS_W = $clog2(DIGITS);

   logic                            resultado_valid;
   logic [calc_pkg::BCD_W*DIGITS-1:0] resultado;
   logic                            resultado_ready;
   logic [calc_pkg::BCD_W-1:0]      digito;
   logic [POS_W-1:0]                digito_pos;
   logic                            digito_en;
   logic                            mostrar;
   logic                            fin;
   logic                            error;

   modport master (
      output resultado_valid,
      output resultado,
      input  resultado_ready,
      input  digito,
      input  digito_pos,
      input  digito_en,
      input  mostrar,
      input  fin,
      input  error
   );

   modport slave (
      input  resultado_valid,
      input  resultado,
      output resultado_ready,
      output digito,
      output digito_pos,
      output digito_en,
      output mostrar,
      output fin,
      output error
   );

endinterface

// File: rtl/contador_permanencia.sv
// Digit-slot hold counter. Cleared during the slot's enable cycle, so the
// terminal flag marks the last cycle of a HOLD_CYCLES-long slot.
module contador_permanencia #(
   parameter int unsigned HOLD_CYCLES = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_terminal
);

   localparam int unsigned CNT_W = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
   // The enable cycle is not counted here, and the count starts at 0 on the
   // first hold cycle: the last slot cycle therefore sees HOLD_CYCLES-2.
   localparam logic [CNT_W-1:0] TC = CNT_W'(HOLD_CYCLES - 2);

   logic [CNT_W-1:0] r_cnt;

   // Count hold cycles, saturating at the terminal value
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_enable && !o_terminal) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_terminal = (r_cnt == TC);

endmodule

// File: rtl/modulo_mostrar_resultado.sv
// Result display sequencer: accepts a BCD result, then presents its digits
// MS first, one HOLD_CYCLES slot each, with leading-zero blanking and
// non-BCD flagging. All outputs are registered.
module modulo_mostrar_resultado
   import calc_pkg::*;
#(
   parameter int unsigned DIGITS      = 4,
   parameter int unsigned HOLD_CYCLES = 4,
   parameter bit          BLANK_ZEROS = 1'b1
) (
   input logic                       clk,
   input logic                       reset,
   modulo_mostrar_resultado_if.slave bus
);

   localparam int unsigned POS_W  = $clog2(DIGITS);
   localparam int unsigned RES_W  = BCD_W * DIGITS;
   localparam logic [POS_W-1:0] POS_MS = POS_W'(DIGITS - 1);

   estado_t          r_estado;
   logic [RES_W-1:0] r_resultado;
   logic [POS_W-1:0] r_pos;
   logic [BCD_W-1:0] r_digito;
   logic             r_en;
   logic             r_mostrar;
   logic             r_fin;
   logic             r_error;
   logic             r_ready;

   logic             w_accept;
   logic             w_terminal;
   logic [POS_W-1:0] w_pos_next;
   logic [BCD_W:0]   w_vista_next;
   logic [BCD_W:0]   w_vista_acc;

   function automatic logic [BCD_W-1:0] extraer_digito(input logic [RES_W-1:0] res,
                                                        input logic [POS_W-1:0] pos);
      logic [BCD_W-1:0] d;
      d = '0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (pos == POS_W'(i)) d = res[BCD_W*i +: BCD_W];
      end
      return d;
   endfunction

   // True when the digit at pos and every more significant digit are 0
   function automatic logic ceros_superiores(input logic [RES_W-1:0] res,
                                             input logic [POS_W-1:0] pos);
      logic z;
      z = 1'b1;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (POS_W'(i) >= pos && res[BCD_W*i +: BCD_W] != '0) z = 1'b0;
      end
      return z;
   endfunction

   function automatic logic hay_error(input logic [RES_W-1:0] res);
      logic e;
      e = 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
         if (res[BCD_W*i +: BCD_W] > 4'd9) e = 1'b1;
      end
      return e;
   endfunction

   // Returns {mostrar, digito} for one slot; a non-BCD digit is nonzero,
   // so it also stops blanking of the digits below it.
   function automatic logic [BCD_W:0] vista(input logic [RES_W-1:0] res,
                                            input logic [POS_W-1:0] pos);
      logic [BCD_W-1:0] d;
      d = extraer_digito(res, pos);
      if (d > 4'd9) return {1'b1, ERR};
      if (BLANK_ZEROS && pos != '0 && ceros_superiores(res, pos)) return {1'b0, BLANK};
      return {1'b1, d};
   endfunction

   // Slot contents prepared one cycle ahead so they are stable from ENABLE on
   always_comb begin
      w_accept     = r_ready & bus.resultado_valid;
      w_pos_next   = r_pos - POS_W'(1);
      w_vista_next = vista(r_resultado, w_pos_next);
      w_vista_acc  = vista(bus.resultado, POS_MS);
   end

   contador_permanencia #(
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_contador (
      .clk        (clk),
      .reset      (reset),
      .i_clear    (r_estado == ENABLE),
      .i_enable   (r_estado == MOSTRAR),
      .o_terminal (w_terminal)
   );

   // Sequencer FSM with registered outputs
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_estado    <= ESPERAR;
         r_resultado <= '0;
         r_pos       <= '0;
         r_digito    <= '0;
         r_en        <= 1'b0;
         r_mostrar   <= 1'b0;
         r_fin       <= 1'b0;
         r_error     <= 1'b0;
         r_ready     <= 1'b1;
      end else begin
         r_en  <= 1'b0;
         r_fin <= 1'b0;
         case (r_estado)
            ESPERAR: begin
               if (w_accept) begin
                  r_resultado             <= bus.resultado;
                  r_pos                   <= POS_MS;
                  {r_mostrar, r_digito}   <= w_vista_acc;
                  r_error                 <= hay_error(bus.resultado);
                  r_en                    <= 1'b1;
                  r_ready                 <= 1'b0;
                  r_estado                <= ENABLE;
               end
            end
            ENABLE: begin
               r_estado <= MOSTRAR;
            end
            MOSTRAR: begin
               if (w_terminal) begin
                  if (r_pos == '0) begin
                     r_mostrar <= 1'b0;
                     r_fin     <= 1'b1;
                     r_estado  <= FIN;
                  end else begin
                     r_pos                 <= w_pos_next;
                     {r_mostrar, r_digito} <= w_vista_next;
                     r_en                  <= 1'b1;
                     r_estado              <= ENABLE;
                  end
               end
            end
            FIN: begin
               r_ready  <= 1'b1;
               r_estado <= ESPERAR;
            end
            default: begin
               r_estado <= ESPERAR;
            end
         endcase
      end
   end

   assign bus.resultado_ready = r_ready;
   assign bus.digito          = r_digito;
   assign bus.digito_pos      = r_pos;
   assign bus.digito_en       = r_en;
   assign bus.mostrar         = r_mostrar;
   assign bus.fin             = r_fin;
   assign bus.error           = r_error;

endmodule

// File: tb/tb_modulo_mostrar_resultado.sv
// Bench for modulo_mostrar_resultado: default instance driven from a vector
// table through a scoreboard, plus a HOLD_CYCLES=2 / no-blanking instance.
module tb_modulo_mostrar_resultado;
   import calc_pkg::*;

   localparam int NDIG = 4;
   localparam int HOLD = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;

   always #5 clk = ~clk;

   modulo_mostrar_resultado_if #(.DIGITS(NDIG)) bus1 ();
   modulo_mostrar_resultado_if #(.DIGITS(NDIG)) bus2 ();

   modulo_mostrar_resultado #(
      .DIGITS      (NDIG),
      .HOLD_CYCLES (HOLD),
      .BLANK_ZEROS (1'b1)
   ) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus1)
   );

   modulo_mostrar_resultado #(
      .DIGITS      (NDIG),
      .HOLD_CYCLES (2),
      .BLANK_ZEROS (1'b0)
   ) dut2 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus2)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [15:0] res;
      logic [15:0] dig;   // expected displayed code per position
      logic [3:0]  mos;   // expected mostrar per position
      logic        err;
   } vec_t;

   typedef struct {
      bit         is_fin;
      int         cyc;
      logic [1:0] pos;
      logic [3:0] dig;
      logic       mos;
      logic       err;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   cyc      = 0;
   int   edge_cnt = 0;
   int   acc_edges[$];

   // Cycle numbering: the accept edge is cycle 0, the next period is cycle 1
   always @(posedge clk) begin
      edge_cnt++;
      if (reset && bus1.resultado_valid && bus1.resultado_ready) begin
         cyc = 1;
         acc_edges.push_back(edge_cnt);
      end else begin
         cyc++;
      end
   end

   logic [3:0] cur_dig;
   logic [1:0] cur_pos;
   logic       cur_mos;
   bit         in_slot = 0;

   // Monitor: every enable or fin pulse pops one scoreboard entry
   always @(negedge clk) begin
      if (bus1.digito_en === 1'b1 || bus1.fin === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: en=%0b fin=%0b at cycle %0d, expected none",
                     bus1.digito_en, bus1.fin, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("event_kind", 32'(bus1.fin), 32'(mon_e.is_fin));
            chk("event_cycle", 32'(cyc), 32'(mon_e.cyc));
            chk("busy_ready", 32'(bus1.resultado_ready), 32'd0);
            if (!mon_e.is_fin) begin
               chk("slot_pos", 32'(bus1.digito_pos), 32'(mon_e.pos));
               chk("slot_digito", 32'(bus1.digito), 32'(mon_e.dig));
               chk("slot_mostrar", 32'(bus1.mostrar), 32'(mon_e.mos));
               chk("slot_error", 32'(bus1.error), 32'(mon_e.err));
               cur_dig = mon_e.dig;
               cur_pos = mon_e.pos;
               cur_mos = mon_e.mos;
               in_slot = 1;
            end else begin
               in_slot = 0;
            end
         end
      end else if (in_slot && bus1.resultado_ready === 1'b0) begin
         chk("hold_digito", 32'(bus1.digito), 32'(cur_dig));
         chk("hold_pos", 32'(bus1.digito_pos), 32'(cur_pos));
         chk("hold_mostrar", 32'(bus1.mostrar), 32'(cur_mos));
      end
      if (bus1.resultado_ready === 1'b1) in_slot = 0;
   end

   task automatic push_exp(input vec_t v);
      exp_t e;
      for (int k = 0; k < NDIG; k++) begin
         int p;
         p        = NDIG - 1 - k;
         e.is_fin = 0;
         e.cyc    = 1 + k * HOLD;
         e.pos    = 2'(p);
         e.dig    = v.dig[4*p +: 4];
         e.mos    = v.mos[p];
         e.err    = v.err;
         exp_q.push_back(e);
      end
      e.is_fin = 1;
      e.cyc    = 1 + NDIG * HOLD;
      e.pos    = '0;
      e.dig    = '0;
      e.mos    = 1'b0;
      e.err    = v.err;
      exp_q.push_back(e);
   endtask

   // Called at a negedge; returns at the negedge of cycle 1
   task automatic send(input logic [15:0] res);
      int n;
      n = 0;
      while (bus1.resultado_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout: ready=%0b after 100 cycles, expected 1", bus1.resultado_ready);
      end
      bus1.resultado_valid = 1'b1;
      bus1.resultado       = res;
      @(negedge clk);
      bus1.resultado_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d events pending, expected 0", exp_q.size());
         exp_q.delete();
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, 32'(bus1.resultado_ready), 32'd1);
      chk({tag, "_digito"}, 32'(bus1.digito), 32'd0);
      chk({tag, "_pos"}, 32'(bus1.digito_pos), 32'd0);
      chk({tag, "_en"}, 32'(bus1.digito_en), 32'd0);
      chk({tag, "_mostrar"}, 32'(bus1.mostrar), 32'd0);
      chk({tag, "_fin"}, 32'(bus1.fin), 32'd0);
      chk({tag, "_error"}, 32'(bus1.error), 32'd0);
   endtask

   vec_t vecs[7];
   vec_t v1234;
   vec_t v5678;
   int   base;

   initial begin
      vecs[0] = '{16'h0042, 16'hFF42, 4'b0011, 1'b0};
      vecs[1] = '{16'h0000, 16'hFFF0, 4'b0001, 1'b0};
      vecs[2] = '{16'h1A05, 16'h1E05, 4'b1111, 1'b1};
      vecs[3] = '{16'h0900, 16'hF900, 4'b0111, 1'b0};
      vecs[4] = '{16'h00A0, 16'hFFE0, 4'b0011, 1'b1};
      vecs[5] = '{16'h9000, 16'h9000, 4'b1111, 1'b0};
      vecs[6] = '{16'h0001, 16'hFFF1, 4'b0001, 1'b0};
      v1234   = '{16'h1234, 16'h1234, 4'b1111, 1'b0};
      v5678   = '{16'h5678, 16'h5678, 4'b1111, 1'b0};

      bus1.resultado_valid = 1'b0;
      bus1.resultado       = '0;
      bus2.resultado_valid = 1'b0;
      bus2.resultado       = '0;
      reset                = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_idle("reset");
      reset = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++) begin
         push_exp(vecs[i]);
         send(vecs[i].res);
         wait_drain();
      end

      // valid held high: second accept lands 18 edges after the first and
      // captures the data present then, not the data present at cycle 1
      base = acc_edges.size();
      push_exp(v1234);
      push_exp(v5678);
      bus1.resultado_valid = 1'b1;
      bus1.resultado       = 16'h1234;
      @(negedge clk);
      bus1.resultado       = 16'h5678;
      for (int n = 0; n < 100 && acc_edges.size() < base + 2; n++) @(negedge clk);
      bus1.resultado_valid = 1'b0;
      if (acc_edges.size() >= base + 2) begin
         chk("accept_spacing", 32'(acc_edges[base+1] - acc_edges[base]), 32'(1 + NDIG * HOLD + 1));
      end else begin
         checks++;
         errors++;
         $display("FAIL accept_spacing: %0d accepts seen, expected 2", acc_edges.size() - base);
      end
      wait_drain();

      // Reset low during cycle 7 of a transfer
      push_exp(v1234);
      send(16'h1234);
      repeat (6) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      chk_idle("midreset");
      reset = 1'b1;
      repeat (20) @(negedge clk);
      push_exp(vecs[0]);
      send(vecs[0].res);
      wait_drain();

      // HOLD_CYCLES=2, no blanking: every digit shown
      bus2.resultado       = 16'h0007;
      bus2.resultado_valid = 1'b1;
      @(negedge clk);
      bus2.resultado_valid = 1'b0;
      for (int c = 1; c <= 11; c++) begin
         bit e_en;
         int p;
         if (c > 1) @(negedge clk);
         e_en = (c <= 8) && ((c - 1) % 2 == 0);
         p    = 3 - (c - 1) / 2;
         chk("d2_en", 32'(bus2.digito_en), 32'(e_en));
         chk("d2_fin", 32'(bus2.fin), 32'(c == 9));
         chk("d2_ready", 32'(bus2.resultado_ready), 32'(c >= 10));
         if (c <= 8) begin
            chk("d2_pos", 32'(bus2.digito_pos), 32'(p));
            chk("d2_digito", 32'(bus2.digito), (p == 0) ? 32'd7 : 32'd0);
            chk("d2_mostrar", 32'(bus2.mostrar), 32'd1);
            chk("d2_error", 32'(bus2.error), 32'd0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
